// File: rtl/fp_addsub_unit.sv
// Multi-cycle IEEE-754 style floating-point add/subtract with runtime rounding and exception flags.
// Define FP_ADDSUB_FTZ_EN to flush subnormal inputs and subnormal results to signed zero.
module fp_addsub_unit #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op,
    input  logic [1:0]           rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int FW   = MAN_W + 4;
    localparam int EW1  = EXP_W + 1;
    localparam int SH_W = $clog2(FW + 1) + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_TOP = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W:0]   ONE_E   = EW1'(1);
    localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    function automatic logic round_up(input logic [1:0] m, input logic s, input logic lsb,
                                      input logic g, input logic r, input logic st);
        case (m)
            2'b00:   round_up = g & (r | st | lsb);
            2'b01:   round_up = 1'b0;
            2'b10:   round_up = !s & (g | r | st);
            default: round_up = s & (g | r | st);
        endcase
    endfunction

    function automatic logic [W-1:0] ovf_result(input logic [1:0] m, input logic s);
        logic to_inf;
        case (m)
            2'b00:   to_inf = 1'b1;
            2'b01:   to_inf = 1'b0;
            2'b10:   to_inf = !s;
            default: to_inf = s;
        endcase
        return to_inf ? {s, EXP_MAX, {MAN_W{1'b0}}} : {s, EXP_TOP, {MAN_W{1'b1}}};
    endfunction

    function automatic int lzc(input logic [FW-1:0] v);
        int n;
        n = FW;
        for (int i = 0; i < FW; i++)
            if (v[i]) n = FW - 1 - i;
        return n;
    endfunction

    logic [2:0]       state;
    logic [W-1:0]     a_q, b_q;
    logic [1:0]       rm_q;
    logic             sign_p0, sub_p0;
    logic [EXP_W:0]   exp_p0, exp_p1, exp_p2;
    logic [FW-1:0]    sig_l_p0, sig_s_p0, sig_p2;
    logic [FW:0]      sum_p1;
    logic             zero_p2;

    assign in_ready = rst_n && (state == S_IDLE);

    // ALIGN: unpack, classify, order by magnitude and align the smaller significand
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, el, es, el_eff, es_eff, diff;
    logic [MAN_W-1:0] fa, fb, fa_x, fb_x, fl, fs;
    logic             nan_a, nan_b, inf_a, inf_b, special, swap, spec_nv;
    logic [W-1:0]     spec_res;
    logic [FW-1:0]    sig_l_c, sig_s_c;
    logic [2*FW-1:0]  wide;
    logic [SH_W-1:0]  dc;

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;
`ifdef FP_ADDSUB_FTZ_EN
    assign fa_x = (ea == '0) ? '0 : fa;
    assign fb_x = (eb == '0) ? '0 : fb;
`else
    assign fa_x = fa;
    assign fb_x = fb;
`endif
    assign nan_a   = (ea == EXP_MAX) && (fa != '0);
    assign nan_b   = (eb == EXP_MAX) && (fb != '0);
    assign inf_a   = (ea == EXP_MAX) && (fa == '0);
    assign inf_b   = (eb == EXP_MAX) && (fb == '0);
    assign special = nan_a || nan_b || inf_a || inf_b;
    assign spec_nv = (nan_a && !fa[MAN_W-1]) || (nan_b && !fb[MAN_W-1]) ||
                     (inf_a && inf_b && (sa != sb));

    always_comb begin
        spec_res = QNAN;
        if (!nan_a && !nan_b && !(inf_a && inf_b && (sa != sb)))
            spec_res = inf_a ? {sa, EXP_MAX, {MAN_W{1'b0}}} : {sb, EXP_MAX, {MAN_W{1'b0}}};
    end

    always_comb begin
        swap    = {eb, fb_x} > {ea, fa_x};
        el      = swap ? eb : ea;
        es      = swap ? ea : eb;
        fl      = swap ? fb_x : fa_x;
        fs      = swap ? fa_x : fb_x;
        el_eff  = (el == '0) ? EXP_W'(1) : el;
        es_eff  = (es == '0) ? EXP_W'(1) : es;
        diff    = el_eff - es_eff;
        sig_l_c = {(el != '0), fl, 3'b000};
        dc      = (32'(diff) > FW) ? SH_W'(FW) : SH_W'(diff);
        wide    = {(es != '0), fs, 3'b000, {FW{1'b0}}} >> dc;
        sig_s_c = {wide[2*FW-1:FW+1], wide[FW] | (|wide[FW-1:0])};
    end

    // NORM: carry right-shift or exponent-limited left-shift
    int             lz, lim, sh;
    logic [FW-1:0]  norm_sig;
    logic [EXP_W:0] norm_exp;

    always_comb begin
        lz  = lzc(sum_p1[FW-1:0]);
        lim = int'(exp_p1) - 1;
        sh  = (lz < lim) ? lz : lim;
        if (sum_p1[FW]) begin
            norm_sig = {sum_p1[FW:2], sum_p1[1] | sum_p1[0]};
            norm_exp = exp_p1 + ONE_E;
        end else begin
            norm_sig = sum_p1[FW-1:0] << sh;
            norm_exp = exp_p1 - EW1'(sh);
        end
    end

    // ROUND: apply rounding mode, then resolve overflow, underflow and exact zero
    logic [MAN_W:0]   mant, mant_f;
    logic [MAN_W+1:0] mant_r;
    logic [EXP_W:0]   exp_f;
    logic             nx, up, hid, ovf;
    logic [W-1:0]     rnd_res;
    logic [3:0]       rnd_flags;

    always_comb begin
        mant   = sig_p2[FW-1:3];
        nx     = |sig_p2[2:0];
        up     = round_up(rm_q, sign_p0, mant[0], sig_p2[2], sig_p2[1], sig_p2[0]);
        mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, up};
        mant_f = mant_r[MAN_W+1] ? mant_r[MAN_W+1:1] : mant_r[MAN_W:0];
        exp_f  = mant_r[MAN_W+1] ? exp_p2 + ONE_E : exp_p2;
        hid    = mant_f[MAN_W];
        ovf    = hid && (exp_f >= {1'b0, EXP_MAX});
        rnd_res   = {sign_p0, (hid ? exp_f[EXP_W-1:0] : '0), mant_f[MAN_W-1:0]};
        rnd_flags = {2'b00, !hid && nx, nx};
        if (zero_p2) begin
            rnd_res   = {(sub_p0 ? (rm_q == 2'b11) : sign_p0), {(W-1){1'b0}}};
            rnd_flags = 4'b0000;
        end else if (ovf) begin
            rnd_res   = ovf_result(rm_q, sign_p0);
            rnd_flags = 4'b0101;
        end
`ifdef FP_ADDSUB_FTZ_EN
        else if (!hid) begin
            rnd_res   = {sign_p0, {(W-1){1'b0}}};
            rnd_flags = 4'b0011;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rm_q      <= '0;
            sign_p0   <= 1'b0;
            sub_p0    <= 1'b0;
            exp_p0    <= '0;
            exp_p1    <= '0;
            exp_p2    <= '0;
            sig_l_p0  <= '0;
            sig_s_p0  <= '0;
            sum_p1    <= '0;
            sig_p2    <= '0;
            zero_p2   <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= {b[W-1] ^ op, b[W-2:0]};
                    rm_q  <= rnd_mode;
                    state <= S_ALIGN;
                end
                S_ALIGN: if (special) begin
                    result <= spec_res;
                    flags  <= {spec_nv, 3'b000};
                    state  <= S_DONE;
                end else begin
                    sign_p0  <= swap ? sb : sa;
                    sub_p0   <= sa ^ sb;
                    exp_p0   <= {1'b0, el_eff};
                    sig_l_p0 <= sig_l_c;
                    sig_s_p0 <= sig_s_c;
                    state    <= S_ADD;
                end
                S_ADD: begin
                    sum_p1 <= sub_p0 ? {1'b0, sig_l_p0} - {1'b0, sig_s_p0}
                                     : {1'b0, sig_l_p0} + {1'b0, sig_s_p0};
                    exp_p1 <= exp_p0;
                    state  <= S_NORM;
                end
                S_NORM: begin
                    sig_p2  <= norm_sig;
                    exp_p2  <= norm_exp;
                    zero_p2 <= (sum_p1 == '0);
                    state   <= S_ROUND;
                end
                S_ROUND: begin
                    result <= rnd_res;
                    flags  <= rnd_flags;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_unit.sv
// Directed self-checking bench for fp_addsub_unit in single-precision configuration.
module tb_fp_addsub_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        op;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_pass = 0;
    int n_total = 0;

    fp_addsub_unit #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .rnd_mode(rnd_mode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    // Issue one operation, wait (bounded) for out_valid, capture, then complete the handshake.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                         input logic [1:0] trm, output logic [31:0] r, output logic [3:0] f,
                         output int lat);
        @(negedge clk);
        a = ta; b = tb_v; op = top; rnd_mode = trm; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (!out_valid) begin
            n_total++;
            $display("FAIL timeout: out_valid never rose for %h op %0d %h", ta, top, tb_v);
        end
        r = result;
        f = flags;
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = 1'b0; rnd_mode = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result); else n_pass++;
        n_total++; if (flags !== 4'h0) $display("FAIL reset_flags got %b want 0000", flags); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_add_basic();
        logic [31:0] r; logic [3:0] f; int lat;
        do_op(32'h3F800000, 32'h40000000, 1'b0, 2'b00, r, f, lat);
        n_total++; if (r !== 32'h40400000) $display("FAIL add_1p2_result got %h want 40400000", r); else n_pass++;
        n_total++; if (f !== 4'b0000) $display("FAIL add_1p2_flags got %b want 0000", f); else n_pass++;
        n_total++; if (lat !== 5) $display("FAIL add_latency got %0d want 5", lat); else n_pass++;
    endtask

    task automatic test_sub_zero();
        logic [31:0] r; logic [3:0] f; int lat;
        do_op(32'h3F800000, 32'h3F800000, 1'b1, 2'b00, r, f, lat);
        n_total++; if (r !== 32'h00000000) $display("FAIL sub_zero_rne got %h want 00000000", r); else n_pass++;
        n_total++; if (f !== 4'b0000) $display("FAIL sub_zero_rne_flags got %b want 0000", f); else n_pass++;
        do_op(32'h3F800000, 32'h3F800000, 1'b1, 2'b11, r, f, lat);
        n_total++; if (r !== 32'h80000000) $display("FAIL sub_zero_rdn got %h want 80000000", r); else n_pass++;
        n_total++; if (f !== 4'b0000) $display("FAIL sub_zero_rdn_flags got %b want 0000", f); else n_pass++;
    endtask

    task automatic test_specials();
        logic [31:0] r; logic [3:0] f; int lat;
        do_op(32'h7F800000, 32'hFF800000, 1'b0, 2'b00, r, f, lat);
        n_total++; if (r !== 32'h7FC00000) $display("FAIL inf_minus_inf got %h want 7FC00000", r); else n_pass++;
        n_total++; if (f !== 4'b1000) $display("FAIL inf_minus_inf_flags got %b want 1000", f); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL special_latency got %0d want 2", lat); else n_pass++;
        do_op(32'h7F800001, 32'h3F800000, 1'b0, 2'b00, r, f, lat);
        n_total++; if (r !== 32'h7FC00000) $display("FAIL snan_result got %h want 7FC00000", r); else n_pass++;
        n_total++; if (f !== 4'b1000) $display("FAIL snan_flags got %b want 1000", f); else n_pass++;
        do_op(32'hFF800000, 32'h3F800000, 1'b0, 2'b00, r, f, lat);
        n_total++; if ({r, f} !== {32'hFF800000, 4'b0000}) $display("FAIL single_inf got %h/%b want FF800000/0000", r, f); else n_pass++;
    endtask

    task automatic test_rounding();
        logic [31:0] r; logic [3:0] f; int lat;
        do_op(32'h3F800000, 32'h33800000, 1'b0, 2'b00, r, f, lat);
        n_total++; if (r !== 32'h3F800000) $display("FAIL tie_rne got %h want 3F800000", r); else n_pass++;
        n_total++; if (f !== 4'b0001) $display("FAIL tie_rne_flags got %b want 0001", f); else n_pass++;
        do_op(32'h3F800000, 32'h33800000, 1'b0, 2'b10, r, f, lat);
        n_total++; if (r !== 32'h3F800001) $display("FAIL tie_rup got %h want 3F800001", r); else n_pass++;
        n_total++; if (f !== 4'b0001) $display("FAIL tie_rup_flags got %b want 0001", f); else n_pass++;
        do_op(32'h00000001, 32'h00000001, 1'b0, 2'b00, r, f, lat);
`ifdef FP_ADDSUB_FTZ_EN
        n_total++; if (r !== 32'h00000000) $display("FAIL subnormal_add got %h want 00000000", r); else n_pass++;
`else
        n_total++; if (r !== 32'h00000002) $display("FAIL subnormal_add got %h want 00000002", r); else n_pass++;
        n_total++; if (f !== 4'b0000) $display("FAIL subnormal_add_flags got %b want 0000", f); else n_pass++;
`endif
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic [3:0] f; int lat;
        do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, r, f, lat);
        n_total++; if (r !== 32'h7F800000) $display("FAIL ovf_rne got %h want 7F800000", r); else n_pass++;
        n_total++; if (f !== 4'b0101) $display("FAIL ovf_rne_flags got %b want 0101", f); else n_pass++;
        do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, r, f, lat);
        n_total++; if (r !== 32'h7F7FFFFF) $display("FAIL ovf_rtz got %h want 7F7FFFFF", r); else n_pass++;
        n_total++; if (f !== 4'b0101) $display("FAIL ovf_rtz_flags got %b want 0101", f); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic [3:0] f; int lat;
        do_op(32'h3F800000, 32'h40000000, 1'b0, 2'b00, r, f, lat);
        n_total++; if (r !== 32'h40400000) $display("FAIL b2b_first got %h want 40400000", r); else n_pass++;
        do_op(32'h40000000, 32'h3F800000, 1'b1, 2'b00, r, f, lat);
        n_total++; if (r !== 32'h3F800000) $display("FAIL b2b_second got %h want 3F800000", r); else n_pass++;
    endtask

    task automatic test_backpressure_reset();
        logic [31:0] r; logic [3:0] f; int lat;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; op = 1'b0; rnd_mode = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = 32'h7F800000; b = 32'hFF800000; in_valid = 1'b1;
            @(posedge clk);
            #1;
            n_total++;
            if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 32'h40400000, 4'h0})
                $display("FAIL hold_cycle_%0d got v=%b rdy=%b %h/%b want v=1 rdy=0 40400000/0000",
                         i, out_valid, in_ready, result, flags);
            else n_pass++;
        end
        @(negedge clk) begin in_valid = 1'b0; out_ready = 1'b1; end
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL release_handshake got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); else n_pass++;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; op = 1'b0; rnd_mode = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_round_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL rst_round_result got %h want 00000000", result); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_round_in_ready got %b want 0", in_ready); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        do_op(32'h3F800000, 32'h40000000, 1'b0, 2'b00, r, f, lat);
        n_total++; if (r !== 32'h40400000) $display("FAIL post_reset_result got %h want 40400000", r); else n_pass++;
        n_total++; if (lat !== 5) $display("FAIL post_reset_latency got %0d want 5", lat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_sub_zero();
        test_specials();
        test_rounding();
        test_overflow();
        test_back_to_back();
        test_backpressure_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
